ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), to the keyboard over the same PS2_CLK/PS2_DATA open-collector pair that keyboard_signal receives on. The top level wires each line as `oe ? 1'b0 : 1'bz` and feeds the pad value back in. `busy` lets keyboard_signal ignore bus activity caused by the host frame.

## Interface

- INHIBIT_CYCLES, 12000: clock-inhibit hold, 120 µs at 100 MHz.
- START_TIMEOUT_CYCLES, 1500000: maximum wait for the device's first clock edge, 15 ms.
- XFER_TIMEOUT_CYCLES, 200000: maximum time from the first device edge to bus idle, 2 ms.
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-low reset.
- tx_valid  in  1  request to send tx_data.
- tx_data  in  8  command byte.
- tx_ready  out  1  high only in IDLE; a transfer is accepted on the cycle tx_valid && tx_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the device acknowledges the byte.
- err  out  1  one-cycle pulse when a transfer fails.
- err_code  out  2  01 start timeout, 10 transfer timeout, 11 NACK; holds until the next err.
- ps2_clk_in  in  1  PS2_CLK pad value.
- ps2_data_in  in  1  PS2_DATA pad value.
- ps2_clk_oe  out  1  1 pulls PS2_CLK low.
- ps2_data_oe  out  1  1 pulls PS2_DATA low.

## Operation

- Input conditioning:
  - Both pad inputs pass through a 2-flop synchronizer; its flops reset to 1.
  - A falling edge means the synchronized clock was 1 in the previous cycle and is 0 now.
- On accept, the block latches tx_data and the odd parity bit, parity = ~^tx_data.
- Frame bit index k runs 0..9:
  - k = 0..7: data bits, LSB first.
  - k = 8: parity.
  - k = 9: stop bit, which releases the line.
- States and transitions:
  - IDLE: both oe = 0. On accept go to INHIBIT and clear the counter.
  - INHIBIT: clk_oe = 1, data_oe = 0. Go to START after INHIBIT_CYCLES cycles.
  - START: clk_oe = 1, data_oe = 1 for exactly 1 cycle, then go to WAIT_CLK.
  - WAIT_CLK: clk_oe = 0, data_oe = 1 (start bit).
    - On the first falling edge: drive bit k = 0, clear the counter, go to SHIFT.
    - After START_TIMEOUT_CYCLES cycles with no edge: err with code 01.
  - SHIFT: on each falling edge, k increments and data_oe = ~bit[k]. When the edge that drives k = 9 (stop, data_oe = 0) has occurred, go to ACK.
  - ACK: on the next falling edge (the 11th), sample the synchronized data.
    - 0: go to WAIT_IDLE.
    - 1: err with code 11.
  - WAIT_IDLE: when synchronized clk and data are both 1, pulse done and go to IDLE.
- XFER_TIMEOUT_CYCLES counts from entry to SHIFT across SHIFT, ACK and WAIT_IDLE. Expiry raises err with code 10.
- Any err releases both oe in the same cycle and returns to IDLE.
- done and err are never asserted together; exactly one of them pulses per accepted request.
- tx_valid while busy is ignored; the block has no queue.
- A request accepted while the device is mid-transmission still proceeds. The inhibit aborts the device frame, and the device retransmits later.

## Timing

- Reset (asynchronous, immediate), outputs:
  - state IDLE;
  - ps2_clk_oe = 0, ps2_data_oe = 0;
  - busy = 0, tx_ready = 1;
  - done = 0, err = 0, err_code = 00.
- All outputs are registered except tx_ready and busy, which decode state.
- Handshake latency:
  - Accept at cycle 0.
  - ps2_clk_oe = 1 from cycle 1 through cycle INHIBIT_CYCLES.
  - ps2_data_oe rises at cycle INHIBIT_CYCLES + 1.
  - ps2_clk_oe falls at cycle INHIBIT_CYCLES + 2.
- Edge-to-drive latency: a pad falling edge at cycle t changes data_oe at t + 3 (2 synchronizer cycles, 1 register). This is well within the device's ≥5 µs clock-low phase.
- Counters are 21 bits and saturate-compare with ">= parameter − 1"; they never wrap.
- Reset asserted mid-frame releases both lines in the same instant. No done or err is produced for the aborted frame.
- done and err fire in the cycle after the detecting condition.

## Test plan

Benches use INHIBIT_CYCLES = 100, START_TIMEOUT_CYCLES = 2000, XFER_TIMEOUT_CYCLES = 5000, with a device model clocking at a 50-cycle half period.

- Send 0xED:
  - ps2_clk_oe is high for 100 cycles, then START.
  - The data line after successive falling edges reads 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - The device acks with 0, then one done pulse; busy falls; err stays 0.
- Send 0xF4: the data line reads 0,0,1,0,1,1,1,1, parity 0, stop 1, then done.
- Device never clocks: err with err_code = 01 at about 2000 cycles after WAIT_CLK entry; both oe = 0; tx_ready = 1.
- Device holds data high on the 11th edge: err with err_code = 11 and no done.
- Device stops clocking after 5 edges: err with err_code = 10 at 5000 cycles after SHIFT entry; lines released.
- Reset mid-frame and busy requests:
  - rst low during SHIFT: both oe drop to 0 immediately, tx_ready = 1, no pulse.
  - tx_valid pulsed while busy is ignored; only one frame is seen on the bus.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: handshake, status and pad bundle for the PS/2 host transmitter.
//   tx_valid/tx_data/tx_ready : command-byte request handshake
//   busy/done/err/err_code    : transfer status
//   ps2_clk_in/ps2_data_in    : pad values read back from the open-collector lines
//   ps2_clk_oe/ps2_data_oe    : 1 pulls the corresponding line low
// slave is the transmitter side; master is the requester and pad side.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport slave (
    input  tx_valid, tx_data, ps2_clk_in, ps2_data_in,
    output tx_ready, busy, done, err, err_code, ps2_clk_oe, ps2_data_oe
  );

  modport master (
    output tx_valid, tx_data, ps2_clk_in, ps2_data_in,
    input  tx_ready, busy, done, err, err_code, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the device clock, issues a request-to-send, then shifts one byte
// plus odd parity and stop on the device's falling clock edges and checks
// the device acknowledge.
//   clk : system clock
//   rst : asynchronous reset, active low
//   bus : ps2_host_tx_if.slave (handshake, status, pad in / pad pull-down)
// err_code: 01 start timeout, 10 transfer timeout, 11 NACK; held until next err.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES       = 12000,
  parameter int unsigned START_TIMEOUT_CYCLES = 1500000,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = 200000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus
);

  localparam logic [20:0] INHIBIT_LAST = 21'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] START_LAST   = 21'(START_TIMEOUT_CYCLES - 1);
  localparam logic [20:0] XFER_LAST    = 21'(XFER_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_WAIT_CLK,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_START = 2'b01,
    ERR_XFER  = 2'b10,
    ERR_NACK  = 2'b11
  } err_e;

  state_e      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic [20:0] cnt_inc;
  logic [9:0]  frame_q, frame_d;   // {stop, parity, data}; bit 0 is on the line
  logic [3:0]  idx_q, idx_d;       // frame bit index currently driven
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [2:0]  clk_sync_q, clk_sync_d;   // [1] synchronized, [2] previous
  logic [1:0]  data_sync_q, data_sync_d;

  logic clk_s, data_s, clk_fall;
  logic xfer_phase, xfer_expired;

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], bus.ps2_clk_in};
    data_sync_d = {data_sync_q[0], bus.ps2_data_in};
  end

  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign cnt_inc  = cnt_q + 21'd1;

  // One timeout spans SHIFT, ACK and WAIT_IDLE, so it is checked ahead of
  // the per-state logic rather than repeated in each branch.
  assign xfer_phase   = (state_q == S_SHIFT) || (state_q == S_ACK) ||
                        (state_q == S_WAIT_IDLE);
  assign xfer_expired = (cnt_q >= XFER_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    if (xfer_phase && xfer_expired) begin
      state_d    = S_IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_XFER;
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          if (bus.tx_valid) begin
            frame_d  = {1'b1, ~^bus.tx_data, bus.tx_data};
            idx_d    = 4'd0;
            cnt_d    = '0;
            clk_oe_d = 1'b1;
            state_d  = S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (cnt_q >= INHIBIT_LAST) begin
            cnt_d     = '0;
            data_oe_d = 1'b1;
            state_d   = S_START;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_START: begin
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          state_d  = S_WAIT_CLK;
        end

        // The start bit stays on the line until the device's first edge.
        S_WAIT_CLK: begin
          if (clk_fall) begin
            idx_d     = 4'd0;
            data_oe_d = ~frame_q[0];
            cnt_d     = '0;
            state_d   = S_SHIFT;
          end else if (cnt_q >= START_LAST) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_START;
            data_oe_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_SHIFT: begin
          cnt_d = cnt_inc;
          if (clk_fall) begin
            frame_d   = {1'b0, frame_q[9:1]};
            idx_d     = idx_q + 4'd1;
            data_oe_d = ~frame_q[1];
            if (idx_q == 4'd8) begin
              state_d = S_ACK;
            end
          end
        end

        S_ACK: begin
          cnt_d = cnt_inc;
          if (clk_fall) begin
            if (data_s) begin
              state_d    = S_IDLE;
              err_d      = 1'b1;
              err_code_d = ERR_NACK;
              clk_oe_d   = 1'b0;
              data_oe_d  = 1'b0;
            end else begin
              state_d = S_WAIT_IDLE;
            end
          end
        end

        S_WAIT_IDLE: begin
          cnt_d = cnt_inc;
          if (clk_s && data_s) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d   = S_IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      frame_q     <= '0;
      idx_q       <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign bus.tx_ready    = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;

endmodule
